// File: rtl/glitchless_pkg.sv
// Shared types for the glitch-free burst controller: state encoding,
// default parameter values and the state-to-control-output decode.
package glitchless_pkg;

    localparam int BURST_W_DEF     = 4;
    localparam int TIMEOUT_CYC_DEF = 8;
    localparam int DLY_CYC_DEF     = 1;

    // Unused encodings (5..7) are steered back to IDLE by the FSM.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        DLY    = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } state_t;

    typedef struct packed {
        logic rd;
        logic wr;
        logic ds;
        logic busy;
        logic timeout;
    } ctrl_t;

    // Control outputs that belong to a given state. rd/wr depend on the
    // captured direction, so it is passed in alongside the state.
    function automatic ctrl_t decode_state(state_t s, logic wr_dir);
        ctrl_t c;
        c = '0;
        case (s)
            ACCESS, DLY: begin
                c.rd   = !wr_dir;
                c.wr   = wr_dir;
                c.busy = 1'b1;
            end
            DONE: begin
                c.ds   = 1'b1;
                c.busy = 1'b1;
            end
            ERR: begin
                c.timeout = 1'b1;
                c.busy    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/glitchless_burst_fsm_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over inc.
// Used for the per-beat retry count and the optional transaction stats.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, hold at all-ones, return to zero on clear or reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/glitchless_burst_fsm.sv
// Burst read/write controller with registered (glitch-free) strobes.
// Every output is decoded from next_state and registered, so outputs
// move on the same clock edge as the state and never see an input
// combinationally. The current state is exported on 'state' for debug.
// Optional build macro: GLITCHLESS_TXN_STATS_EN adds saturating counts of
// completed (txn_ok_cnt) and timed-out (txn_err_cnt) bursts.
module glitchless_burst_fsm
    import glitchless_pkg::*;
#(
    parameter int BURST_W     = BURST_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int DLY_CYC     = DLY_CYC_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               go,
    input  logic               wr_mode,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               ws,
    output logic               rd,
    output logic               wr,
    output logic               ds,
    output logic               busy,
    output logic               timeout,
    output logic [BURST_W-1:0] beat_cnt,
    output state_t             state
`ifdef GLITCHLESS_TXN_STATS_EN
    ,
    output logic [15:0]        txn_ok_cnt,
    output logic [15:0]        txn_err_cnt
`endif
);

    localparam int RETRY_W = 8;
    localparam int DLY_W   = 2;
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(TIMEOUT_CYC);
    localparam logic [DLY_W-1:0]   DLY_LOAD  = DLY_W'(DLY_CYC - 1);

    state_t               next_state;
    ctrl_t                ctrl_nxt;
    logic                 wr_mode_q;
    logic                 wr_mode_nxt;
    logic [BURST_W-1:0]   len_q;
    logic [BURST_W-1:0]   len_nxt;
    logic [BURST_W-1:0]   beat_nxt;
    logic [DLY_W-1:0]     dly_cnt;
    logic [DLY_W-1:0]     dly_nxt;
    logic [RETRY_W-1:0]   retry_cnt;
    logic                 retry_clr;
    logic                 retry_inc;

    // Next-state and next-value decode. ws is looked at only on the last
    // DLY cycle; go/wr_mode/burst_len only in IDLE.
    always_comb begin
        next_state  = IDLE;
        wr_mode_nxt = wr_mode_q;
        len_nxt     = len_q;
        beat_nxt    = beat_cnt;
        dly_nxt     = dly_cnt;
        retry_clr   = 1'b0;
        retry_inc   = 1'b0;
        case (state)
            IDLE: begin
                retry_clr = 1'b1;
                dly_nxt   = '0;
                if (go) begin
                    next_state  = ACCESS;
                    wr_mode_nxt = wr_mode;
                    len_nxt     = burst_len;
                    beat_nxt    = '0;
                end else begin
                    next_state = IDLE;
                end
            end
            ACCESS: begin
                next_state = DLY;
                dly_nxt    = DLY_LOAD;
            end
            DLY: begin
                if (dly_cnt != '0) begin
                    next_state = DLY;
                    dly_nxt    = dly_cnt - 1'b1;
                end else if (ws) begin
                    if (retry_cnt < RETRY_LIM) begin
                        next_state = ACCESS;
                        retry_inc  = 1'b1;
                    end else begin
                        next_state = ERR;
                    end
                end else if (beat_cnt < len_q) begin
                    next_state = ACCESS;
                    beat_nxt   = beat_cnt + 1'b1;
                    retry_clr  = 1'b1;
                end else begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: begin
                next_state = IDLE;
                retry_clr  = 1'b1;
            end
        endcase
        ctrl_nxt = decode_state(next_state, wr_mode_nxt);
    end

    // State, captured burst parameters and registered control outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rd        <= 1'b0;
            wr        <= 1'b0;
            ds        <= 1'b0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
            beat_cnt  <= '0;
            dly_cnt   <= '0;
            wr_mode_q <= 1'b0;
            len_q     <= '0;
        end else begin
            state     <= next_state;
            rd        <= ctrl_nxt.rd;
            wr        <= ctrl_nxt.wr;
            ds        <= ctrl_nxt.ds;
            busy      <= ctrl_nxt.busy;
            timeout   <= ctrl_nxt.timeout;
            beat_cnt  <= beat_nxt;
            dly_cnt   <= dly_nxt;
            wr_mode_q <= wr_mode_nxt;
            len_q     <= len_nxt;
        end
    end

    // Consecutive ws retries on the current beat.
    sat_counter #(.WIDTH(RETRY_W)) u_retry (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (retry_clr),
        .inc     (retry_inc),
        .count   (retry_cnt)
    );

`ifdef GLITCHLESS_TXN_STATS_EN
    // DONE and ERR last one cycle and are only entered from DLY, so
    // next_state alone marks each entry.
    sat_counter #(.WIDTH(16)) u_ok_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (1'b0),
        .inc     (next_state == DONE),
        .count   (txn_ok_cnt)
    );

    sat_counter #(.WIDTH(16)) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (1'b0),
        .inc     (next_state == ERR),
        .count   (txn_err_cnt)
    );
`endif

endmodule

// File: tb/tb_glitchless_burst_fsm.sv
// Bench for glitchless_burst_fsm: bursts are planned by a timeline model,
// the expected per-cycle outputs are queued, and a monitor compares them
// whenever the DUT reports busy.
module tb_glitchless_burst_fsm;
    import glitchless_pkg::*;

    localparam int BURST_W     = 4;
    localparam int TIMEOUT_CYC = 8;
    localparam int DLY_CYC     = 1;
    localparam int W           = 5 + BURST_W;

    logic               clk;
    logic               reset_n;
    logic               go;
    logic               wr_mode;
    logic [BURST_W-1:0] burst_len;
    logic               ws;
    logic               rd;
    logic               wr;
    logic               ds;
    logic               busy;
    logic               timeout;
    logic [BURST_W-1:0] beat_cnt;
    state_t             state;
`ifdef GLITCHLESS_TXN_STATS_EN
    logic [15:0]        txn_ok_cnt;
    logic [15:0]        txn_err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic         ws_plan[$];
    int           last_outcome;
    int           exp_ok = 0;
    int           exp_err = 0;
    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_act;

    glitchless_burst_fsm #(
        .BURST_W     (BURST_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .DLY_CYC     (DLY_CYC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .go        (go),
        .wr_mode   (wr_mode),
        .burst_len (burst_len),
        .ws        (ws),
        .rd        (rd),
        .wr        (wr),
        .ds        (ds),
        .busy      (busy),
        .timeout   (timeout),
        .beat_cnt  (beat_cnt),
        .state     (state)
`ifdef GLITCHLESS_TXN_STATS_EN
        ,
        .txn_ok_cnt  (txn_ok_cnt),
        .txn_err_cnt (txn_err_cnt)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, act=running req=finished");
        $fatal(1);
    end

    function automatic logic [W-1:0] pack_exp(bit r, bit w, bit d, bit t, int beat);
        logic [BURST_W-1:0] b;
        b = BURST_W'(beat);
        return {r, w, d, 1'b1, t, b};
    endfunction

    // ws answer for the n-th sample of a burst.
    // mode 0: random (~25% wait), 1: always wait, 2: never wait, 3: wait on sample 1 only
    function automatic bit ws_decide(int mode, int idx);
        case (mode)
            0:       return ($urandom_range(0, 3) == 0);
            1:       return 1'b1;
            3:       return (idx == 1);
            default: return 1'b0;
        endcase
    endfunction

    // Timeline model: one ACCESS cycle plus DLY_CYC DLY cycles per attempt,
    // a wait on the last DLY cycle retries the beat (up to TIMEOUT_CYC
    // retries), then one DONE or ERR cycle. Fills exp_q and ws_plan.
    task automatic plan_burst(input int len, input bit wm, input int mode);
        int  beat;
        int  retry;
        int  idx;
        bit  fin;
        bit  w;
        beat  = 0;
        retry = 0;
        idx   = 0;
        fin   = 1'b0;
        ws_plan.delete();
        while (!fin) begin
            exp_q.push_back(pack_exp(!wm, wm, 1'b0, 1'b0, beat));
            ws_plan.push_back(1'($urandom_range(0, 1)));
            for (int d = 0; d < DLY_CYC - 1; d++) begin
                exp_q.push_back(pack_exp(!wm, wm, 1'b0, 1'b0, beat));
                ws_plan.push_back(1'($urandom_range(0, 1)));
            end
            exp_q.push_back(pack_exp(!wm, wm, 1'b0, 1'b0, beat));
            w = ws_decide(mode, idx);
            idx++;
            ws_plan.push_back(w);
            if (w) begin
                if (retry < TIMEOUT_CYC) begin
                    retry++;
                end else begin
                    exp_q.push_back(pack_exp(1'b0, 1'b0, 1'b0, 1'b1, beat));
                    ws_plan.push_back(1'($urandom_range(0, 1)));
                    last_outcome = 1;
                    fin = 1'b1;
                end
            end else if (beat < len) begin
                beat++;
                retry = 0;
            end else begin
                exp_q.push_back(pack_exp(1'b0, 1'b0, 1'b1, 1'b0, beat));
                ws_plan.push_back(1'($urandom_range(0, 1)));
                last_outcome = 0;
                fin = 1'b1;
            end
        end
    endtask

    // Driver: go for one cycle in IDLE, then follow the planned ws values
    // while scrambling go/wr_mode/burst_len, which must be ignored.
    task automatic run_burst(input int len, input bit wm, input int mode);
        plan_burst(len, wm, mode);
        @(negedge clk);
        go        = 1'b1;
        wr_mode   = wm;
        burst_len = BURST_W'(len);
        ws        = 1'($urandom_range(0, 1));
        foreach (ws_plan[j]) begin
            @(negedge clk);
            ws        = ws_plan[j];
            go        = 1'($urandom_range(0, 1));
            wr_mode   = 1'($urandom_range(0, 1));
            burst_len = BURST_W'($urandom);
        end
        if (last_outcome == 0) exp_ok++;
        else exp_err++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            go        = 1'b0;
            wr_mode   = 1'($urandom_range(0, 1));
            burst_len = BURST_W'($urandom);
            ws        = 1'($urandom_range(0, 1));
        end
    endtask

    // Reset during beat 2 of a 6-beat write: outputs must drop at once.
    task automatic mid_reset();
        bit hit;
        hit = 1'b0;
        plan_burst(5, 1'b1, 2);
        @(negedge clk);
        go        = 1'b1;
        wr_mode   = 1'b1;
        burst_len = BURST_W'(5);
        ws        = 1'b0;
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (beat_cnt == BURST_W'(2)) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL mid_reset_reach_beat2: act beat_cnt=%0d req=2", beat_cnt);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rd, wr, ds, busy, timeout, beat_cnt} !== '0 || state !== IDLE) begin
            errors++;
            $display("FAIL mid_reset_outputs: act=%b state=%0d req=0 state=0",
                     {rd, wr, ds, busy, timeout, beat_cnt}, state);
        end
        exp_q.delete();
        exp_ok  = 0;
        exp_err = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor: pops one expectation per busy cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            mon_act = {rd, wr, ds, busy, timeout, beat_cnt};
            if (busy === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_busy: act=%b req=idle", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        errors++;
                        $display("FAIL burst_cycle t=%0t: act rd,wr,ds,busy,to,beat=%b req=%b",
                                 $time, mon_act, mon_exp);
                    end
                end
            end else begin
                checks++;
                if ({rd, wr, ds, timeout} !== 4'b0000) begin
                    errors++;
                    $display("FAIL idle_strobes t=%0t: act rd,wr,ds,to=%b req=0000",
                             $time, {rd, wr, ds, timeout});
                end
            end
        end
    end

    // Stimulus sequence and final report.
    initial begin
        reset_n   = 1'b0;
        go        = 1'b0;
        wr_mode   = 1'b0;
        burst_len = '0;
        ws        = 1'b0;
        #10;
        checks++;
        if ({rd, wr, ds, busy, timeout, beat_cnt} !== '0 || state !== IDLE) begin
            errors++;
            $display("FAIL reset_values: act=%b state=%0d req=0 state=0",
                     {rd, wr, ds, busy, timeout, beat_cnt}, state);
        end
        #6;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ((^{rd, wr, ds, busy, timeout, beat_cnt, state}) === 1'bx) begin
            errors++;
            $display("FAIL x_after_reset: act=%b req=known",
                     {rd, wr, ds, busy, timeout, beat_cnt});
        end

        idle(1);
        run_burst(0, 1'b0, 2);        // single read, no waits
        idle(1);
        run_burst(3, 1'b1, 3);        // write burst, one wait on beat 1
        idle(2);
        run_burst(0, 1'b0, 1);        // ws held -> timeout
        idle(1);
        run_burst(15, 1'b1, 2);       // longest burst, beat_cnt ends at all-ones
        run_burst(2, 1'b0, 0);        // back-to-back start
        idle(1);
        mid_reset();
        idle(1);
        run_burst(1, 1'b0, 2);        // fresh burst after reset starts at beat 0
        for (int n = 0; n < 30; n++) begin
            run_burst($urandom_range(0, 15), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0) ? 1 : 0);
            idle($urandom_range(0, 2));
        end
        idle(4);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: act %0d expected cycles never seen req=0", exp_q.size());
        end
`ifdef GLITCHLESS_TXN_STATS_EN
        checks++;
        if (txn_ok_cnt !== 16'(exp_ok)) begin
            errors++;
            $display("FAIL txn_ok_cnt: act=%0d req=%0d", txn_ok_cnt, exp_ok);
        end
        checks++;
        if (txn_err_cnt !== 16'(exp_err)) begin
            errors++;
            $display("FAIL txn_err_cnt: act=%0d req=%0d", txn_err_cnt, exp_err);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/glitchless_burst_fsm.md
Name: glitchless_burst_fsm

Overview:
- Parametrised successor to the single-access rd/ds memory-handshake FSM: burst read/write controller whose control outputs are all registered, so they are glitch-free.
- Sits between a requesting engine (go, wr_mode, burst_len) and a slow memory/peripheral that inserts wait states via ws.
- Adds multi-beat bursts, write mode, bounded wait-state retries with timeout, and a busy/done/error status interface.

Parameters:
- BURST_W, 4, width of burst_len and beat counter; burst = burst_len+1 beats (1..2^BURST_W).
- TIMEOUT_CYC, 8, maximum consecutive ws retries per beat before abort (1..255).
- DLY_CYC, 1, number of DLY cycles per beat before ws is sampled (1..4).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- go  in  1  start request, sampled only in IDLE.
- wr_mode  in  1  0 = read burst, 1 = write burst; captured with go.
- burst_len  in  BURST_W  beats minus one; captured with go.
- ws  in  1  wait-state request from memory, sampled on last DLY cycle.
- rd  out  1  read strobe, registered.
- wr  out  1  write strobe, registered.
- ds  out  1  data-strobe/done-strobe, high for exactly one cycle in DONE.
- busy  out  1  high in every state except IDLE.
- timeout  out  1  one-cycle pulse in ERR.
- beat_cnt  out  BURST_W  index of the current beat (0-based), registered.

Behaviour:
- States: IDLE, ACCESS, DLY, DONE, ERR; encoding in package.
- Outputs are decoded from next_state and registered, so each output changes on the same edge as the state. No combinational path from any input to any output.
- Reset (async, reset_n=0): state=IDLE; rd=wr=ds=busy=timeout=0; beat_cnt=0; all internal counters=0. Deassertion is synchronous to clk via the normal flop path.
- IDLE:
  - go=1 -> ACCESS; capture wr_mode and burst_len; beat_cnt=0.
  - go=0 -> stay.
- ACCESS: 1 cycle, then DLY; dly counter loads DLY_CYC-1.
- DLY:
  - Lasts DLY_CYC cycles; ws is sampled on the last of them.
  - ws=1 and retry<TIMEOUT_CYC -> ACCESS with the same beat; retry+1.
  - ws=1 and retry==TIMEOUT_CYC -> ERR.
  - ws=0 and beat_cnt<len -> ACCESS; beat_cnt+1; retry=0.
  - ws=0 and beat_cnt==len -> DONE.
- DONE: ds=1 for 1 cycle -> IDLE. go during DONE is ignored; a new burst needs go in IDLE.
- ERR: timeout=1 for 1 cycle -> IDLE; ds stays 0.
- rd = !wr_mode_q in ACCESS/DLY; wr = wr_mode_q in ACCESS/DLY. rd and wr are never both 1; both are 0 in IDLE/DONE/ERR.
- Latency: go high at edge k -> rd/wr high after edge k. Single beat, DLY_CYC=1, no ws: ds high after edge k+2, busy low after edge k+3.
- ws and go are ignored outside their sampling states; burst_len/wr_mode changes mid-burst have no effect.
- beat_cnt does not wrap: max len = 2^BURST_W-1 ends exactly at all-ones.
- Reset asserted mid-burst aborts immediately to IDLE values with no ds or timeout pulse.
- Illegal or unreached state encodings -> IDLE.

Optional Feature:
- Macro: GLITCHLESS_TXN_STATS_EN.
- Defined: adds outputs txn_ok_cnt[15:0] and txn_err_cnt[15:0].
  - txn_ok_cnt increments on each entry to DONE; txn_err_cnt on each entry to ERR.
  - Both saturate at 16'hFFFF and are cleared by reset_n.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package glitchless_pkg: state_t enum (IDLE, ACCESS, DLY, DONE, ERR), default parameter constants, and a function decoding a state_t into an {rd, wr, ds, busy, timeout} output struct.
- Sub-module sat_counter (parametrised width, inc, clear, saturating) is instantiated for the retry counter and for the stats counters.

Test Plan:
- Reset: reset_n=0 for 1.6 cycles, go=0 -> all outputs 0, state IDLE; no X after release.
- Single read: go=1 for one cycle at 2.6 cycles, len=0, ws=0, DLY_CYC=1 -> rd high 2 cycles, ds 1-cycle pulse 2 cycles after go is sampled, busy 3 cycles.
- Burst write with waits: len=3, wr_mode=1, ws=1 on the first DLY of beat 1 only -> wr high, beat_cnt 0,1,1,2,3, one ds pulse, rd stays 0.
- Timeout: len=0, ws held 1, TIMEOUT_CYC=8 -> 8 retries then a 1-cycle timeout pulse, no ds, back to IDLE.
- Mid-burst reset: reset_n=0 during beat 2 of len=5 -> outputs 0 asynchronously; go after release starts a fresh burst at beat_cnt=0.
- Stats (GLITCHLESS_TXN_STATS_EN): 3 good bursts + 1 timeout -> txn_ok_cnt=3, txn_err_cnt=1; preload near max -> holds at FFFF.
